// File: rtl/stream_mux_n.sv
// N-to-1 valid/ready stream multiplexer with a single-entry output register.
// Channel choice is either an explicit index or round-robin after the last accepted channel.
module stream_mux_n #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic [N-1:0]     in_valid,
    input  logic [WIDTH-1:0] in_data [N],
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_chan,
    input  logic             out_ready,
    output logic [15:0]      xfer_count
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]    chan_q, chan_d;
    logic [SW-1:0]    last_q, last_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             load_en;
    logic             accept;
    logic [N-1:0]     grant;
    logic [SW-1:0]    gidx;
    logic [SW:0]      cand;
    logic [SW-1:0]    cand_s;
    logic             found;

    assign load_en = !valid_q || out_ready;

    // One extra bit on the candidate so last+k can be reduced modulo N.
    always_comb begin
        grant  = '0;
        gidx   = '0;
        found  = 1'b0;
        cand   = '0;
        cand_s = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    grant[i] = 1'b1;
                    gidx     = SW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                cand = {1'b0, last_q} + (SW+1)'(k);
                if (cand >= (SW+1)'(N)) begin
                    cand = cand - (SW+1)'(N);
                end
                cand_s = cand[SW-1:0];
                if (!found && in_valid[cand_s]) begin
                    found         = 1'b1;
                    grant[cand_s] = 1'b1;
                    gidx          = cand_s;
                end
            end
        end
    end

    assign accept   = rst_n && load_en && (|grant);
    assign in_ready = (rst_n && load_en) ? grant : '0;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = in_data[gidx];
            chan_d  = gidx;
            last_d  = gidx;
            cnt_d   = cnt_q + 16'd1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // last resets to N-1 so that channel 0 wins the first round-robin search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            last_q  <= SW'(N - 1);
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_chan   = chan_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: directed scenarios plus randomized traffic
// compared against a behavioural model of the output register and arbiter.
module tb_stream_mux_n;

    localparam int W = 16;
    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic [2:0]    sel;
    logic [N-1:0]  in_valid;
    logic [W-1:0]  in_data [N];
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [2:0]    out_chan;
    logic          out_ready;
    logic [15:0]   xfer_count;

    // Second instance with a non-power-of-two channel count.
    logic [2:0]    sel6;
    logic [5:0]    in_valid6;
    logic [W-1:0]  in_data6 [6];
    logic [5:0]    in_ready6;
    logic          out_valid6;
    logic [W-1:0]  out_data6;
    logic [2:0]    out_chan6;
    logic [15:0]   xfer_count6;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_ov;
    logic [W-1:0] m_data;
    int          m_chan;
    int          m_last;
    int          m_cnt;
    bit          quiet;

    always #5 clk = ~clk;

    stream_mux_n #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready), .xfer_count(xfer_count)
    );

    stream_mux_n #(.WIDTH(W), .N(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .mode(1'b0), .sel(sel6),
        .in_valid(in_valid6), .in_data(in_data6), .in_ready(in_ready6),
        .out_valid(out_valid6), .out_data(out_data6), .out_chan(out_chan6),
        .out_ready(1'b1), .xfer_count(xfer_count6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_grant(input bit md, input int s, input logic [N-1:0] v, input int last);
        if (!md) return v[s] ? s : -1;
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ov = 0; m_data = '0; m_chan = 0; m_last = N - 1; m_cnt = 0;
    endtask

    // Inputs are set by the caller before this; one clock is run and checked.
    task automatic cycle();
        int g;
        bit le;
        logic [N-1:0] exp_rdy;
        #1;
        le = !m_ov || out_ready;
        g = model_grant(mode, int'(sel), in_valid, m_last);
        exp_rdy = (le && g >= 0) ? (N'(1) << g) : '0;
        if (!quiet) check("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        if (le && g >= 0) begin
            m_ov = 1; m_data = in_data[g]; m_chan = g; m_last = g;
            m_cnt = (m_cnt + 1) % 65536;
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
        #1;
        if (!quiet) begin
            check("out_valid", out_valid, m_ov);
            if (m_ov) begin
                check("out_data", out_data, m_data);
                check("out_chan", out_chan, m_chan);
            end
            check("xfer_count", xfer_count, m_cnt);
        end
    endtask

    task automatic set_data_idx();
        for (int i = 0; i < N; i++) in_data[i] = W'(16'h1000 + i);
    endtask

    initial begin
        logic [W-1:0] fz_data;
        logic [2:0]   fz_chan;
        logic [15:0]  fz_cnt;
        int prev;

        quiet = 0;
        rst_n = 0; mode = 0; sel = 0; in_valid = '0; out_ready = 0;
        set_data_idx();
        sel6 = 0; in_valid6 = '0;
        for (int i = 0; i < 6; i++) in_data6[i] = W'(16'h2000 + i);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        in_valid = '1; out_ready = 1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_count", xfer_count, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1;

        // Explicit select, all channels valid
        mode = 0; sel = 3;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("sel3_in_ready", in_ready, 8'h08);
            check("sel3_data", out_data, 16'h1003);
            check("sel3_chan", out_chan, 3);
        end

        // Round-robin from reset
        rst_n = 0; model_reset(); #1; @(negedge clk); rst_n = 1;
        mode = 1; in_valid = 8'hFF; out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("rr_seq", out_chan, i % N);
        end
        check("rr_count10", xfer_count, 10);

        // Two sparse channels alternate, then a stall
        in_valid = 8'b1000_0010;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("alt_chan", out_chan, (i % 2 == 0) ? 7 : 1);
            prev = int'(out_chan);
        end
        fz_data = out_data; fz_chan = out_chan; fz_cnt = xfer_count;
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < N; j++) in_data[j] = W'($urandom);
            cycle();
            check("stall_data", out_data, fz_data);
            check("stall_chan", out_chan, fz_chan);
            check("stall_count", xfer_count, fz_cnt);
            check("stall_ready", in_ready, 0);
        end
        out_ready = 1;
        cycle();
        check("after_stall_chan", out_chan, (prev == 7) ? 1 : 7);

        // Selected channel not valid: output drains
        mode = 0; sel = 5; in_valid = 8'hDF;
        cycle();
        cycle();
        check("sel5_drained", out_valid, 0);

        // N=6 instance: out-of-range select grants nothing
        sel6 = 3'd7; in_valid6 = 6'h3F;
        #1;
        check("n6_sel7", in_ready6, 6'h00);
        sel6 = 3'd5;
        #1;
        check("n6_sel5", in_ready6, 6'h20);

        // Asynchronous reset with a beat held
        mode = 1; in_valid = 8'hFF; out_ready = 1;
        cycle();
        out_ready = 0;
        cycle();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_count", xfer_count, 0);
        check("async_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1;
        mode = 1; in_valid = 8'hFF; out_ready = 1;
        cycle();
        check("post_rst_chan", out_chan, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mode = 1'($urandom);
            sel = 3'($urandom);
            in_valid = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom) : N'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int j = 0; j < N; j++) in_data[j] = W'($urandom);
            cycle();
        end

        // Counter wrap
        rst_n = 0; model_reset(); #1; @(negedge clk); rst_n = 1;
        mode = 1; in_valid = 8'hFF; out_ready = 1;
        quiet = 1;
        for (int i = 0; i < 65534; i++) cycle();
        quiet = 0;
        check("cnt_fffe", xfer_count, 16'hFFFE);
        cycle();
        check("cnt_ffff", xfer_count, 16'hFFFF);
        cycle();
        check("cnt_wrap", xfer_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_n.md
STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 Parameters SHALL be: WIDTH, default 16, data width per channel; N, default 8, channel count (legal range 2..16); SW, default $clog2(N), select/channel-index width.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  mode  in  1  0 = explicit select, 1 = round-robin arbitration
  sel  in  SW  channel index used when mode=0
  in_valid  in  N  per-channel valid
  in_data  in  N x WIDTH  per-channel payload (unpacked array [N])
  in_ready  out  N  per-channel ready
  out_valid  out  1  output register holds a beat
  out_data  out  WIDTH  registered payload
  out_chan  out  SW  channel index of the held beat
  out_ready  in  1  downstream ready
  xfer_count  out  16  accepted-beat counter

Function
REQ-003 The block SHALL hold a single-entry output register (out_valid, out_data, out_chan); input-to-output latency SHALL be exactly 1 cycle.
REQ-004 The register SHALL be able to load ("load_en") when out_valid=0 or out_ready=1, i.e. full-throughput pass-through with a simultaneous drain and load.
REQ-005 The combinational grant SHALL be one-hot or zero; in_ready[i] SHALL be grant[i] AND load_en; no in_ready bit SHALL depend on in_valid of a different channel except through grant.
REQ-006 In mode=0, grant[sel] SHALL equal in_valid[sel]; all other grants SHALL be 0; sel >= N SHALL produce no grant (no default channel).
REQ-007 In mode=1, grant SHALL go to the first asserted in_valid searched from index last+1 upward, wrapping modulo N, where last is the most recently accepted channel index.
REQ-008 An accept SHALL occur on a cycle where load_en=1 and any grant bit is 1; on accept, out_data <= in_data[g], out_chan <= g, out_valid <= 1, last <= g.
REQ-009 When out_valid=1, out_ready=1 and no accept occurs, out_valid SHALL clear next cycle.
REQ-010 When out_valid=1 and out_ready=0, out_valid, out_data and out_chan SHALL remain stable and all in_ready SHALL be 0.
REQ-011 last SHALL update only on accept, in both modes, so a mode 0->1 switch resumes rotation after the last accepted channel.
REQ-012 mode and sel changes SHALL take effect in the same cycle (combinational into grant); no beat SHALL be lost or duplicated by such a change.
REQ-013 xfer_count SHALL increment by 1 on each accept and wrap 16'hFFFF -> 16'h0000 without saturation.
REQ-014 With a single channel continuously valid in mode=1 and out_ready=1, that channel SHALL be accepted every cycle.

Reset
REQ-015 On rst_n=0, asynchronously: out_valid=0, out_data=0, out_chan=0, xfer_count=0, last=N-1 (so channel 0 has first round-robin priority).
REQ-016 in_ready SHALL be 0 for all channels while rst_n=0; a beat in flight at reset assertion SHALL be discarded.
REQ-017 Reset deassertion SHALL be safe at any clock phase; the first accept SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-018 Mode 0, sel=3, in_valid=8'hFF, out_ready=1, in_data[i]=16'h1000+i -> in_ready=8'h08 every cycle, out_data=16'h1003 and out_chan=3 one cycle later, every cycle.
REQ-019 Mode 1 after reset, in_valid=8'hFF, out_ready=1 for 10 cycles -> out_chan sequence 0,1,2,...,7,0,1 and xfer_count=10.
REQ-020 Mode 1, in_valid=8'b1000_0010, out_ready=1 -> alternating channels 1,7,1,7; then out_ready held 0 for 3 cycles -> out_data/out_chan frozen, in_ready=0, no count change.
REQ-021 Mode 0, sel=5 with in_valid[5]=0 and all other channels valid -> no accept, out_valid falls after drain; sel=3'd7 with N=6 -> no grant.
REQ-022 Assert rst_n=0 mid-stream with out_valid=1 -> out_valid, xfer_count drop to 0 without a clock edge; after release in mode 1 the first grant goes to channel 0.
REQ-023 Preload xfer_count to 16'hFFFE via 2 fewer than 65536 accepts (or force), two more accepts -> 16'hFFFF then 16'h0000.
